// File: rtl/ntt_out_collector_pkg.sv
// Shared definitions for the NTT output collector and its users.
package ntt_out_collector_pkg;

   localparam int DW        = 32;  // coefficient word width
   localparam int MAX_DEPTH = 10;  // log2 of the largest supported ring
   localparam int MIN_DEPTH = 2;   // log2 of the smallest supported ring

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_DRAIN
   } coll_state_e;

   // True when a requested ring depth is one this block can collect.
   function automatic logic depth_ok(input logic [3:0] depth, input int max_depth);
      return (int'(depth) >= MIN_DEPTH) && (int'(depth) <= max_depth);
   endfunction

endpackage

// File: rtl/ntt_coef_ram.sv
// Simple dual-port coefficient store: synchronous write, registered read.
module ntt_coef_ram #(
   parameter int DW = ntt_out_collector_pkg::DW,
   parameter int AW = ntt_out_collector_pkg::MAX_DEPTH
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // Write port.
   // NOTE: the array carries no reset; every location is written before it
   // is read, and a reset would stop the tools mapping this onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read port; rdata holds its value whenever re is low.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ntt_out_collector.sv
// Collects bit-interleaved NTT output words, fully reduces them mod q and
// replays them in natural coefficient order over a ready/valid stream.
module ntt_out_collector #(
   parameter int DW        = ntt_out_collector_pkg::DW,
   parameter int MAX_DEPTH = ntt_out_collector_pkg::MAX_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           ring_depth,
   input  logic [DW-1:0]        q,
   input  logic                 in_valid,
   input  logic [DW-1:0]        in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic [MAX_DEPTH-1:0] out_idx,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   import ntt_out_collector_pkg::*;

   localparam int AW = MAX_DEPTH;

   coll_state_e   state_q, state_d;

   logic [3:0]    depth_q;
   logic [DW-1:0] q_q;
   logic [AW:0]   n_words;     // N, one bit wider so 2^MAX_DEPTH fits
   logic [AW-1:0] half_n;
   logic [AW-1:0] last_idx;    // N-1

   logic [AW-1:0] wr_cnt;      // input word count m
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_en;

   logic [AW:0]   rd_addr;     // next address to read, runs 0..N
   logic          rd_en;
   logic [DW-1:0] ram_rdata;
   logic          ram_vld;     // ram_rdata holds a word not yet moved out
   logic [AW-1:0] ram_idx;     // index of the word in ram_rdata
   logic          load_out;    // output register may take a new word

   logic          start_ok;
   logic          drain_last;
   logic          err_set;

   assign n_words  = (AW+1)'(1) << depth_q;
   assign half_n   = n_words[AW:1];
   assign last_idx = AW'(n_words - (AW+1)'(1));

   // De-interleave: even words fill the lower half, odd words the upper half.
   assign wr_en   = (state_q == ST_COLLECT) && in_valid;
   assign wr_addr = (wr_cnt >> 1) + (wr_cnt[0] ? half_n : '0);
   assign wr_data = (in_data >= q_q) ? (in_data - q_q) : in_data;

   assign load_out = !out_valid || out_ready;
   assign rd_en    = (state_q == ST_DRAIN) && (rd_addr != n_words) &&
                     (!ram_vld || load_out);

   assign busy = (state_q != ST_IDLE);

   // Next-state logic and the one-cycle control strobes.
   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      start_ok   = 1'b0;
      drain_last = 1'b0;
      err_set    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) err_set = 1'b1;
            if (start) begin
               if (depth_ok(ring_depth, MAX_DEPTH)) begin
                  start_ok = 1'b1;
                  state_d  = ST_COLLECT;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         ST_COLLECT: begin
            if (start) err_set = 1'b1;
            if (in_valid && (wr_cnt == last_idx)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (start || in_valid) err_set = 1'b1;
            if (out_valid && out_ready && (out_idx == last_idx)) begin
               drain_last = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Run parameters, counters, read pipeline, output register and flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         depth_q   <= '0;
         q_q       <= '0;
         wr_cnt    <= '0;
         rd_addr   <= '0;
         ram_vld   <= 1'b0;
         ram_idx   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= drain_last;

         if (start_ok) begin
            depth_q <= ring_depth;
            q_q     <= q;
            wr_cnt  <= '0;
            rd_addr <= '0;
         end else if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
         end

         if (rd_en) begin
            rd_addr <= rd_addr + 1'b1;
            ram_idx <= rd_addr[AW-1:0];
         end

         if (rd_en)         ram_vld <= 1'b1;
         else if (load_out) ram_vld <= 1'b0;

         if (load_out) begin
            out_valid <= ram_vld;
            if (ram_vld) begin
               out_data <= ram_rdata;
               out_idx  <= ram_idx;
            end
         end

         if (err_set)       err <= 1'b1;
         else if (start_ok) err <= 1'b0;
      end
   end

   ntt_coef_ram #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (rd_en),
      .raddr (rd_addr[AW-1:0]),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_ntt_out_collector.sv
// Scoreboard bench for ntt_out_collector.
module tb_ntt_out_collector;

   localparam int DW = 32;
   localparam int AW = 10;

   logic          clk;
   logic          reset;
   logic          start;
   logic [3:0]    ring_depth;
   logic [DW-1:0] q;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_idx;
   logic          busy;
   logic          done;
   logic          err;

   ntt_out_collector #(.DW(DW), .MAX_DEPTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .ring_depth (ring_depth),
      .q          (q),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_idx    (out_idx),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] sb_data[$];
   int            sb_idx[$];
   logic [DW-1:0] words[1024];
   logic [DW-1:0] pat4[4] = '{32'd7681, 32'd15361, 32'd7680, 32'd0};
   int            done_cnt = 0;
   int            ready_mode = 0;
   int            cur_last = 0;
   int            last_hs_idx = 0;
   bit            prev_valid = 0;
   bit            prev_ready = 0;
   bit            prev_hs = 0;
   logic [DW-1:0] prev_data = '0;
   logic [AW-1:0] prev_idx = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Consumer: always ready, or the repeating 1,0,0,1 pattern.
   initial begin
      int ph = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) begin
            out_ready = 1'b1;
         end else begin
            out_ready = (ph == 0) || (ph == 3);
            ph = (ph + 1) % 4;
         end
      end
   end

   // Output monitor: stability while stalled, gap-free stream, scoreboard, done timing.
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 0;
         prev_ready = 0;
         prev_hs    = 0;
      end else begin
         if (prev_valid && !prev_ready) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
            check("hold_idx", out_idx, prev_idx);
         end else if (prev_valid && sb_data.size() > 0) begin
            check("gap_free", out_valid, 1);
         end
         if (done) begin
            done_cnt++;
            check("done_busy", busy, 0);
            check("done_after_hs", prev_hs, 1);
            check("done_last_idx", last_hs_idx, cur_last);
         end
         if (out_valid && out_ready) begin
            if (sb_data.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               logic [DW-1:0] ed;
               int            ei;
               ed = sb_data.pop_front();
               ei = sb_idx.pop_front();
               check("out_idx", out_idx, ei);
               check("out_data", out_data, ed);
            end
            last_hs_idx = int'(out_idx);
         end
         prev_hs    = out_valid && out_ready;
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
         prev_idx   = out_idx;
      end
   end

   // One complete collection of words[0..N-1]; returns in the done cycle.
   task automatic run(input int depth, input logic [DW-1:0] qv);
      int n;
      int budget;
      bit seen;
      n = 1 << depth;
      @(posedge clk);
      #1;
      start      = 1'b1;
      ring_depth = 4'(depth);
      q          = qv;
      cur_last   = n - 1;
      for (int k = 0; k < n; k++) begin
         int            m;
         logic [DW-1:0] w;
         m = (k < n / 2) ? 2 * k : 2 * (k - n / 2) + 1;
         w = words[m];
         sb_data.push_back((w >= qv) ? w - qv : w);
         sb_idx.push_back(k);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int m = 0; m < n; m++) begin
         in_valid = 1'b1;
         in_data  = words[m];
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_data  = '0;
      budget = 4 * n + 50;
      seen   = 0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("done_seen", seen, 1);
      check("sb_empty", sb_data.size(), 0);
      check("err_clear", err, 0);
      check("busy_low", busy, 0);
      sb_data.delete();
      sb_idx.delete();
   endtask

   initial begin
      int d0;
      reset      = 1'b1;
      start      = 1'b0;
      ring_depth = '0;
      q          = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);

      // Stray in_valid in IDLE
      @(posedge clk);
      #1 in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("err_stray_valid", err, 1);
      check("busy_stray_valid", busy, 0);

      // Ramp input, N=256 (clears err)
      for (int m = 0; m < 256; m++) words[m] = DW'(m);
      run(8, 7681);

      // Reduction boundary pattern
      for (int m = 0; m < 256; m++) words[m] = pat4[m % 4];
      run(8, 7681);

      // Stalling consumer with random lazily-reduced words
      ready_mode = 1;
      for (int m = 0; m < 256; m++) words[m] = DW'($urandom_range(0, 2 * 7681 - 1));
      run(8, 7681);
      ready_mode = 0;

      // Out-of-range ring depth
      @(posedge clk);
      #1;
      start      = 1'b1;
      ring_depth = 4'd11;
      q          = 7681;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("err_bad_depth", err, 1);
      check("busy_bad_depth", busy, 0);
      for (int m = 0; m < 4; m++) words[m] = DW'(100 + m);
      run(2, 7681);

      // Reset in the middle of an N=1024 collection
      @(posedge clk);
      #1;
      start      = 1'b1;
      ring_depth = 4'd10;
      q          = 7681;
      @(posedge clk);
      #1 start = 1'b0;
      d0 = done_cnt;
      for (int m = 0; m < 100; m++) begin
         in_valid = 1'b1;
         in_data  = DW'(m);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
      check("abort_out_data", out_data, 0);
      check("abort_out_idx", out_idx, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_err", err, 0);
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, d0);

      // Fresh small run, then back-to-back N=4 -> N=256
      words[0] = 9; words[1] = 8; words[2] = 7; words[3] = 6;
      run(2, 7681);
      for (int m = 0; m < 4; m++) words[m] = DW'(7681 + 3 * m);
      run(2, 7681);
      for (int m = 0; m < 256; m++) words[m] = DW'($urandom_range(0, 2 * 7681 - 1));
      run(8, 7681);

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
